// File: rtl/cnt_pkg.sv
// Shared types and helpers for the modulo step counter.
package cnt_pkg;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int   MAX_W    = 32;

  // A modulus of zero stands for the full 2^width range.
  function automatic logic [MAX_W:0] eff_mod(input logic [MAX_W-1:0] mod_val, input int width);
    logic [MAX_W:0] m;
    if (mod_val == {MAX_W{1'b0}}) begin
      m = {{MAX_W{1'b0}}, 1'b1} << width;
    end else begin
      m = {1'b0, mod_val};
    end
    return m;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and terminal/wrap/out-of-range decode for mod_counter_seq.
module mod_counter_next
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH:0]   m,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next_count,
  output logic [WIDTH-1:0] terminal,
  output logic             at_terminal,
  output logic             wrap_evt,
  output logic             out_of_range
);

  logic [WIDTH-1:0] m_last_s;
  logic [WIDTH-1:0] one_s;

  assign m_last_s = WIDTH'(m - {{WIDTH{1'b0}}, 1'b1});
  assign one_s    = {{(WIDTH-1){1'b0}}, 1'b1};

  // Decode the step from the current count, modulus and direction.
  always_comb begin
    out_of_range = ({1'b0, count} >= m);
    terminal     = (up_dn == DIR_UP) ? m_last_s : {WIDTH{1'b0}};
    at_terminal  = !out_of_range && (count == terminal);
    next_count   = count;
    wrap_evt     = 1'b0;
    if (out_of_range) begin
      // A modulus lowered under the count forces a restart from zero.
      next_count = {WIDTH{1'b0}};
      wrap_evt   = 1'b1;
    end else if (up_dn == DIR_UP) begin
      if (count == m_last_s) begin
        next_count = {WIDTH{1'b0}};
        wrap_evt   = 1'b1;
      end else begin
        next_count = count + one_s;
        wrap_evt   = 1'b0;
      end
    end else if (up_dn == DIR_DOWN) begin
      if (count == {WIDTH{1'b0}}) begin
        next_count = m_last_s;
        wrap_evt   = 1'b1;
      end else begin
        next_count = count - one_s;
        wrap_evt   = 1'b0;
      end
    end else begin
      next_count = count;
      wrap_evt   = 1'b0;
    end
  end

endmodule

// File: rtl/mod_counter_seq.sv
// Programmable modulo up/down counter with one-shot halt, cascade tc, wrap pulse and done flag.
// Optional sticky range-error output enabled by defining MOD_COUNTER_ERR_EN.
module mod_counter_seq
  import cnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
`ifdef MOD_COUNTER_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic             done_r;

  logic [WIDTH:0]   m_s;
  logic [WIDTH-1:0] m_last_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] terminal_s;
  logic             at_terminal_s;
  logic             wrap_evt_s;
  logic             oor_s;
  logic             load_oor_s;
  logic [WIDTH-1:0] load_clamp_s;
  logic             step_s;

  assign m_s          = (WIDTH+1)'(eff_mod(MAX_W'(mod_val), WIDTH));
  assign m_last_s     = WIDTH'(m_s - {{WIDTH{1'b0}}, 1'b1});
  assign load_oor_s   = ({1'b0, load_val} >= m_s);
  assign load_clamp_s = load_oor_s ? m_last_s : load_val;
  assign step_s       = en && (state_r == RUN);

  mod_counter_next #(.WIDTH(WIDTH)) u_next (
    .count        (count_r),
    .m            (m_s),
    .up_dn        (up_dn),
    .next_count   (next_s),
    .terminal     (terminal_s),
    .at_terminal  (at_terminal_s),
    .wrap_evt     (wrap_evt_s),
    .out_of_range (oor_s)
  );

  // Count, wrap pulse, done flag and RUN/HALT state with reset > clr > load > en priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= RST_COUNT;
      wrap_r  <= 1'b0;
      done_r  <= 1'b0;
      state_r <= RUN;
    end else if (clr) begin
      count_r <= RST_COUNT;
      wrap_r  <= 1'b0;
      done_r  <= 1'b0;
      state_r <= RUN;
    end else if (load) begin
      count_r <= load_clamp_s;
      wrap_r  <= 1'b0;
      done_r  <= 1'b0;
      state_r <= RUN;
    end else if (step_s) begin
      if (oneshot) begin
        wrap_r <= 1'b0;
        if (at_terminal_s) begin
          // Already sitting on the terminal: stop here instead of wrapping.
          done_r  <= 1'b1;
          state_r <= HALT;
        end else begin
          count_r <= next_s;
          if (next_s == terminal_s) begin
            done_r  <= 1'b1;
            state_r <= HALT;
          end else begin
            state_r <= RUN;
          end
        end
      end else begin
        count_r <= next_s;
        wrap_r  <= wrap_evt_s;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

`ifdef MOD_COUNTER_ERR_EN
  logic err_r;

  // Sticky record of any out-of-range load or step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (clr) begin
      err_r <= 1'b0;
    end else if (load) begin
      err_r <= err_r | load_oor_s;
    end else if (step_s) begin
      err_r <= err_r | oor_s;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

  assign count = count_r;
  assign wrap  = wrap_r;
  assign done  = done_r;
  assign tc    = en && at_terminal_s && (state_r == RUN);

endmodule
